// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one cached-memory port between two requesters (0 = instruction
// fetch, 1 = data/LSU). One request is arbitrated and latched at a time. The
// memory enable is then held until mem_done. The response goes back to the
// requester that owns the transaction. If that requester's response buffer is
// full, the data is parked and replayed as a one-cycle done pulse once space
// frees.
//
// Handshake: a requester raises reqN_valid and holds it, together with
// addr/we/wdata, until reqN_ready. reqN_ready is combinational and only asserts
// in IDLE, so there is at most one outstanding transaction. The transfer
// happens on the clock edge where valid && ready.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  requester 0 always wins simultaneous requests
//                      (rr_ptr stays 0). Default (undefined): round-robin.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/addr/we/wdata   request from requester N (N = 0, 1)
//   reqN_ready                 request accepted this cycle
//   respN_full                 requester N response buffer full
//   respN_done/respN_data      one-cycle response pulse and data (0 otherwise)
//   mem_enable/addr/we/wdata   memory-side request (level enable)
//   mem_done/mem_data          memory completion strobe and read data
//   dbg_state                  current FSM state (0 IDLE, 1 BUSY, 2 HOLD)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int BLOCK_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [ADDR_WIDTH-1:0]  req0_addr,
    input  logic                   req0_we,
    input  logic [BLOCK_WIDTH-1:0] req0_wdata,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [ADDR_WIDTH-1:0]  req1_addr,
    input  logic                   req1_we,
    input  logic [BLOCK_WIDTH-1:0] req1_wdata,
    output logic                   req1_ready,
    input  logic                   resp0_full,
    output logic                   resp0_done,
    output logic [BLOCK_WIDTH-1:0] resp0_data,
    input  logic                   resp1_full,
    output logic                   resp1_done,
    output logic [BLOCK_WIDTH-1:0] resp1_data,
    output logic                   mem_enable,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_we,
    output logic [BLOCK_WIDTH-1:0] mem_wdata,
    input  logic                   mem_done,
    input  logic [BLOCK_WIDTH-1:0] mem_data,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   we_q, we_d;
    logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
    logic [BLOCK_WIDTH-1:0] hold_q, hold_d;

    logic                   grant0, grant1;
    logic                   owner_full;
    logic                   resp_done;
    logic [BLOCK_WIDTH-1:0] resp_data;

    assign owner_full = owner_q ? resp1_full : resp0_full;

    // Arbitration. Grants are qualified by rst_n so that every output,
    // including the combinational readies, reads 0 while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_IDLE && rst_n) begin
`ifdef ARB_FIXED_PRIO_EN
            if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
`else
            if (req0_valid && req1_valid) begin
                grant0 = ~rr_ptr_q;
                grant1 = rr_ptr_q;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
        end
    end

    // Next-state and latch updates.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    state_d = ST_BUSY;
                    owner_d = grant1;
                    addr_d  = grant1 ? req1_addr  : req0_addr;
                    we_d    = grant1 ? req1_we    : req0_we;
                    wdata_d = grant1 ? req1_wdata : req0_wdata;
`ifdef ARB_FIXED_PRIO_EN
                    rr_ptr_d = 1'b0;
`else
                    // Point at the requester that did not win this round.
                    rr_ptr_d = ~grant1;
`endif
                end
            end
            ST_BUSY: begin
                if (mem_done) begin
                    if (owner_full) begin
                        hold_d  = mem_data;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (!owner_full) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        resp_done  = 1'b0;
        resp_data  = '0;
        mem_enable = 1'b0;
        case (state_q)
            ST_BUSY: begin
                // The enable drops in the completion cycle only when the
                // response has to be parked. On direct delivery it stays high
                // through the done cycle.
                mem_enable = ~(mem_done & owner_full);
                resp_done  = mem_done & ~owner_full;
                resp_data  = mem_data;
            end
            ST_HOLD: begin
                resp_done = ~owner_full;
                resp_data = hold_q;
            end
            default: begin
                resp_done = 1'b0;
            end
        endcase

        req0_ready = grant0;
        req1_ready = grant1;
        resp0_done = resp_done & ~owner_q;
        resp1_done = resp_done & owner_q;
        resp0_data = (resp_done && !owner_q) ? resp_data : '0;
        resp1_data = (resp_done &&  owner_q) ? resp_data : '0;
        mem_addr   = addr_q;
        mem_we     = we_q;
        mem_wdata  = wdata_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_addr = '0, req1_addr = '0;
    logic        req0_we = 1'b0, req1_we = 1'b0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready;
    logic        resp0_full = 1'b0, resp1_full = 1'b0;
    logic        resp0_done, resp1_done;
    logic [31:0] resp0_data, resp1_data;
    logic        mem_enable, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = '0;
    logic [1:0]  dbg_state;

    mem_port_arbiter #(.BLOCK_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_we(req0_we),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_we(req1_we),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .resp0_full(resp0_full), .resp0_done(resp0_done), .resp0_data(resp0_data),
        .resp1_full(resp1_full), .resp1_done(resp1_done), .resp1_data(resp1_data),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_data(mem_data),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reset with req0 pending: every output must read 0, readies included.
    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        mem_done = 1'b0; resp0_full = 1'b0; resp1_full = 1'b0;
        #1;
        check1("rst_ready0", req0_ready, 1'b0);
        check1("rst_enable", mem_enable, 1'b0);
        check32("rst_state", {30'd0, dbg_state}, 32'd0);
        check32("rst_mem_addr", mem_addr, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        r0v, r1v, r1we, f0, f1, md;
        logic [31:0] mdata;
        logic        e_rdy0, e_rdy1, e_en, e_d0, e_d1;
        logic [31:0] e_data0, e_data1;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(
        input logic r0v, input logic r1v, input logic r1we, input logic f0,
        input logic f1, input logic md, input logic [31:0] mdata,
        input logic e_rdy0, input logic e_rdy1, input logic e_en,
        input logic e_d0, input logic e_d1, input logic [31:0] e_data0,
        input logic [31:0] e_data1, input logic [31:0] e_addr,
        input logic e_we, input logic [31:0] e_wdata);
        vec_t v;
        v.r0v = r0v; v.r1v = r1v; v.r1we = r1we; v.f0 = f0; v.f1 = f1;
        v.md = md; v.mdata = mdata;
        v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_en = e_en;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_data0 = e_data0; v.e_data1 = e_data1;
        v.e_addr = e_addr; v.e_we = e_we; v.e_wdata = e_wdata;
        return v;
    endfunction

    // Reference model state for the random phase.
    logic        m_busy, m_wait, m_owner, m_last_win;
    logic [31:0] m_addr, m_wdata, m_hold;
    logic        m_we;
    logic        p_v[2];
    logic [31:0] p_addr[2], p_wd[2];
    logic        p_we[2];

    initial begin
        logic [31:0] a_const;
        int          exp_w;

        // Fixed request payloads for the directed phases.
        req0_addr = 32'h10; req0_we = 1'b0; req0_wdata = 32'h0;
        req1_addr = 32'h40; req1_wdata = 32'hDEADBEEF;

        // r0v r1v we f0 f1 md mdata | rdy0 rdy1 en d0 d1 data0 data1 addr we wdata
        tbl[0]  = mk(1,0,0,0,0,0,32'h0,        1,0,0,0,0,32'h0,32'h0,32'h0,0,32'h0);
        tbl[1]  = mk(0,0,0,0,0,0,32'h0,        0,0,1,0,0,32'h0,32'h0,32'h10,0,32'h0);
        tbl[2]  = mk(0,0,0,0,0,0,32'h0,        0,0,1,0,0,32'h0,32'h0,32'h10,0,32'h0);
        tbl[3]  = mk(0,0,0,0,0,1,32'hA5A5A5A5, 0,0,1,1,0,32'hA5A5A5A5,32'h0,32'h10,0,32'h0);
        tbl[4]  = mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0,32'h0,32'h0,0,32'h0);
        tbl[5]  = mk(0,1,0,0,0,0,32'h0,        0,1,0,0,0,32'h0,32'h0,32'h0,0,32'h0);
        tbl[6]  = mk(0,0,0,0,0,0,32'h0,        0,0,1,0,0,32'h0,32'h0,32'h40,0,32'hDEADBEEF);
        tbl[7]  = mk(0,0,0,0,1,1,32'h12345678, 0,0,0,0,0,32'h0,32'h0,32'h0,0,32'h0);
        tbl[8]  = mk(0,0,0,0,1,1,32'hFFFFFFFF, 0,0,0,0,0,32'h0,32'h0,32'h0,0,32'h0);
        tbl[9]  = mk(0,0,0,0,1,0,32'h0,        0,0,0,0,0,32'h0,32'h0,32'h0,0,32'h0);
        tbl[10] = mk(0,0,0,0,0,0,32'h0,        0,0,0,0,1,32'h0,32'h12345678,32'h0,0,32'h0);
        tbl[11] = mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0,32'h0,32'h0,0,32'h0);
        tbl[12] = mk(0,1,1,0,0,0,32'h0,        0,1,0,0,0,32'h0,32'h0,32'h0,0,32'h0);
        tbl[13] = mk(0,0,1,0,0,0,32'h0,        0,0,1,0,0,32'h0,32'h0,32'h40,1,32'hDEADBEEF);
        tbl[14] = mk(0,0,1,1,0,0,32'h0,        0,0,1,0,0,32'h0,32'h0,32'h40,1,32'hDEADBEEF);
        tbl[15] = mk(0,0,1,0,0,1,32'hCAFE0000, 0,0,1,0,1,32'h0,32'hCAFE0000,32'h40,1,32'hDEADBEEF);
        tbl[16] = mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0,32'h0,32'h0,0,32'h0);
        tbl[17] = mk(1,0,0,0,0,0,32'h0,        1,0,0,0,0,32'h0,32'h0,32'h0,0,32'h0);
        tbl[18] = mk(0,0,0,0,0,1,32'h00000001, 0,0,1,1,0,32'h1,32'h0,32'h10,0,32'h0);
        tbl[19] = mk(0,0,0,0,0,1,32'h00000007, 0,0,0,0,0,32'h0,32'h0,32'h0,0,32'h0);

        // ---------------- directed table ----------------
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req0_valid = tbl[i].r0v; req1_valid = tbl[i].r1v; req1_we = tbl[i].r1we;
            resp0_full = tbl[i].f0;  resp1_full = tbl[i].f1;
            mem_done = tbl[i].md;    mem_data = tbl[i].mdata;
            #1;
            check1("tbl_ready0", req0_ready, tbl[i].e_rdy0);
            check1("tbl_ready1", req1_ready, tbl[i].e_rdy1);
            check1("tbl_mem_enable", mem_enable, tbl[i].e_en);
            check1("tbl_resp0_done", resp0_done, tbl[i].e_d0);
            check1("tbl_resp1_done", resp1_done, tbl[i].e_d1);
            check32("tbl_resp0_data", resp0_data, tbl[i].e_data0);
            check32("tbl_resp1_data", resp1_data, tbl[i].e_data1);
            if (tbl[i].e_en) begin
                check32("tbl_mem_addr", mem_addr, tbl[i].e_addr);
                check1("tbl_mem_we", mem_we, tbl[i].e_we);
                check32("tbl_mem_wdata", mem_wdata, tbl[i].e_wdata);
            end
        end

        // ---------------- contention, both held ----------------
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 3; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_w = 0;
`else
            exp_w = k % 2;
`endif
            @(negedge clk);
            req0_valid = 1'b1; req1_valid = 1'b1; mem_done = 1'b0;
            #1;
            check1("arb_ready0", req0_ready, exp_w == 0);
            check1("arb_ready1", req1_ready, exp_w == 1);
            @(negedge clk);
            a_const = 32'h100 + 32'(k);
            mem_done = 1'b1; mem_data = a_const;
            #1;
            check1("arb_busy_ready0", req0_ready, 1'b0);
            check1("arb_enable", mem_enable, 1'b1);
            check1("arb_done0", resp0_done, exp_w == 0);
            check1("arb_done1", resp1_done, exp_w == 1);
            check32("arb_data", (exp_w == 0) ? resp0_data : resp1_data, a_const);
            check32("arb_other_data", (exp_w == 0) ? resp1_data : resp0_data, 32'h0);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; mem_done = 1'b0;

        // ---------------- reset while BUSY ----------------
        @(negedge clk);
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check1("rb_enable_before", mem_enable, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1("rb_enable_async", mem_enable, 1'b0);
        check32("rb_state_async", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_done = 1'b1; mem_data = 32'h55;
        #1;
        check1("rb_late_enable", mem_enable, 1'b0);
        check1("rb_late_done0", resp0_done, 1'b0);
        check32("rb_late_data0", resp0_data, 32'h0);
        @(negedge clk);
        mem_done = 1'b0;
        #1;
        check32("rb_state_after", {30'd0, dbg_state}, 32'd0);

        // ---------------- random vs reference model ----------------
        @(negedge clk);
        do_reset();
        m_busy = 1'b0; m_wait = 1'b0; m_owner = 1'b0; m_last_win = 1'b1;
        m_addr = '0; m_we = 1'b0; m_wdata = '0; m_hold = '0;
        for (int i = 0; i < 2; i++) begin
            p_v[i] = 1'b0; p_addr[i] = '0; p_we[i] = 1'b0; p_wd[i] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic g0, g1, own_full, e_en, e_done;
            logic [31:0] e_data;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!p_v[i] && $urandom_range(0, 3) == 0) begin
                    p_v[i] = 1'b1; p_addr[i] = $urandom; p_we[i] = 1'($urandom_range(0, 1));
                    p_wd[i] = $urandom;
                end
            end
            req0_valid = p_v[0]; req0_addr = p_addr[0]; req0_we = p_we[0]; req0_wdata = p_wd[0];
            req1_valid = p_v[1]; req1_addr = p_addr[1]; req1_we = p_we[1]; req1_wdata = p_wd[1];
            resp0_full = ($urandom_range(0, 2) == 0);
            resp1_full = ($urandom_range(0, 2) == 0);
            mem_done   = ($urandom_range(0, 2) == 0);
            mem_data   = $urandom;

            g0 = 1'b0; g1 = 1'b0;
            if (!m_busy) begin
                if (p_v[0] && p_v[1]) begin
`ifdef ARB_FIXED_PRIO_EN
                    g0 = 1'b1;
`else
                    // Alternate: whoever did not win last time goes first.
                    if (m_last_win) g0 = 1'b1; else g1 = 1'b1;
`endif
                end else if (p_v[0]) begin
                    g0 = 1'b1;
                end else if (p_v[1]) begin
                    g1 = 1'b1;
                end
            end
            own_full = m_owner ? resp1_full : resp0_full;
            e_en   = m_busy && !m_wait && !(mem_done && own_full);
            e_done = m_busy && (m_wait ? !own_full : (mem_done && !own_full));
            e_data = m_wait ? m_hold : mem_data;

            #1;
            check1("rnd_ready0", req0_ready, g0);
            check1("rnd_ready1", req1_ready, g1);
            check1("rnd_enable", mem_enable, e_en);
            check1("rnd_done0", resp0_done, e_done && !m_owner);
            check1("rnd_done1", resp1_done, e_done && m_owner);
            check32("rnd_data0", resp0_data, (e_done && !m_owner) ? e_data : 32'h0);
            check32("rnd_data1", resp1_data, (e_done && m_owner) ? e_data : 32'h0);
            if (e_en) begin
                check32("rnd_mem_addr", mem_addr, m_addr);
                check1("rnd_mem_we", mem_we, m_we);
                check32("rnd_mem_wdata", mem_wdata, m_wdata);
            end

            if (g0 || g1) begin
                m_busy = 1'b1; m_wait = 1'b0; m_owner = g1; m_last_win = g1;
                m_addr = p_addr[g1]; m_we = p_we[g1]; m_wdata = p_wd[g1];
                p_v[g1] = 1'b0;
            end else if (m_busy) begin
                if (e_done) begin
                    m_busy = 1'b0; m_wait = 1'b0;
                end else if (!m_wait && mem_done && own_full) begin
                    m_wait = 1'b1; m_hold = mem_data;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
